controller_hazard: RTL and testbench

CONTROLLER_HAZARD -- requirements
Module: controller_hazard

---
 rtl/controller_hazard.sv | 145 ++++++++++++++
 tb/tb_controller_hazard.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_hazard.sv
// controller_hazard: X/M/W stage tracking for a 5-stage RISC-V core, producing
// datapath selects, load-use/RAW stalls, branch flushes and forwarding selects.
module controller_hazard #(
    parameter int                DWIDTH = 32,
    parameter bit                FWD_EN = 1'b1,
    parameter logic [DWIDTH-1:0] NOP    = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] inst_d,
    input  logic              valid_d,
    input  logic              BrEq,
    input  logic              BrLT,
    output logic              stall,
    output logic              flush,
    output logic              PCSel,
    output logic [2:0]        ImmSel,
    output logic              BrUn,
    output logic              ASel,
    output logic              BSel,
    output logic [3:0]        ALUSel,
    output logic [1:0]        FwdA,
    output logic [1:0]        FwdB,
    output logic              MemRW,
    output logic [2:0]        Size,
    output logic [1:0]        WBSel,
    output logic              RegWEn
);
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    logic [DWIDTH-1:0] x_inst, m_inst, w_inst;
    logic              x_valid, m_valid, w_valid;
    logic [4:0]        d_op, x_op, m_op, w_op;
    logic [4:0]        d_rs1, d_rs2, x_rs1, x_rs2, x_rd, m_rd, w_rd;
    logic [2:0]        x_f3;
    logic              d_r1, d_r2, x_r1, x_r2, x_wr, m_wr, w_wr;
    logic              d_hit_x, d_hit_m, hazard, taken, bubble;
    logic              unused_bits;

    function automatic logic writes_rd(input logic [4:0] op, input logic [4:0] rd, input logic v);
        return v && op != OP_STORE && op != OP_BRANCH && rd != 5'd0;
    endfunction

    function automatic logic reads_rs1(input logic [4:0] op);
        return op != OP_LUI && op != OP_AUIPC && op != OP_JAL;
    endfunction

    function automatic logic reads_rs2(input logic [4:0] op);
        return op == OP_OP || op == OP_STORE || op == OP_BRANCH;
    endfunction

    assign d_op  = inst_d[6:2];
    assign d_rs1 = inst_d[19:15];
    assign d_rs2 = inst_d[24:20];
    assign x_op  = x_inst[6:2];
    assign x_rd  = x_inst[11:7];
    assign x_f3  = x_inst[14:12];
    assign x_rs1 = x_inst[19:15];
    assign x_rs2 = x_inst[24:20];
    assign m_op  = m_inst[6:2];
    assign m_rd  = m_inst[11:7];
    assign w_op  = w_inst[6:2];
    assign w_rd  = w_inst[11:7];
    assign unused_bits = ^{inst_d, x_inst, m_inst, w_inst};

    assign d_r1 = reads_rs1(d_op);
    assign d_r2 = reads_rs2(d_op);
    assign x_r1 = reads_rs1(x_op);
    assign x_r2 = reads_rs2(x_op);
    assign x_wr = writes_rd(x_op, x_rd, x_valid);
    assign m_wr = writes_rd(m_op, m_rd, m_valid);
    assign w_wr = writes_rd(w_op, w_rd, w_valid);

    assign d_hit_x = (d_r1 && d_rs1 == x_rd) || (d_r2 && d_rs2 == x_rd);
    assign d_hit_m = (d_r1 && d_rs1 == m_rd) || (d_r2 && d_rs2 == m_rd);

    // With forwarding only a load in X cannot be bypassed; without it any
    // producer still in X or M blocks decode (W is covered by write-through).
    assign hazard = FWD_EN ? (x_wr && x_op == OP_LOAD && d_hit_x)
                           : ((x_wr && d_hit_x) || (m_wr && d_hit_m));

    always_comb begin
        taken  = x_f3 == 3'b000 ? BrEq : x_f3 == 3'b001 ? !BrEq : x_f3[0] ? !BrLT : BrLT;
        PCSel  = x_valid && ((x_op == OP_BRANCH && taken) || x_op == OP_JAL || x_op == OP_JALR);
        flush  = PCSel;
        stall  = valid_d && hazard && !flush;
        bubble = stall || flush;
    end

    always_comb begin
        ImmSel = x_op == OP_STORE ? 3'b001 :
                 x_op == OP_BRANCH ? 3'b010 :
                 (x_op == OP_LUI || x_op == OP_AUIPC) ? 3'b011 :
                 x_op == OP_JAL ? 3'b100 : 3'b000;
        BrUn   = x_f3[2] & x_f3[1];
        ASel   = x_op == OP_BRANCH || x_op == OP_AUIPC || x_op == OP_JAL;
        BSel   = x_op != OP_OP;
        ALUSel = x_op == OP_OP ? {x_inst[30], x_f3} : x_op == OP_IMM ? {1'b0, x_f3} : 4'b0000;
    end

    // Loads in M have no result yet, so only non-load M producers are bypassed.
    always_comb begin
        FwdA = !(FWD_EN && x_r1) ? 2'b00 :
               (m_wr && m_op != OP_LOAD && m_rd == x_rs1) ? 2'b01 :
               (w_wr && w_rd == x_rs1) ? 2'b10 : 2'b00;
        FwdB = !(FWD_EN && x_r2) ? 2'b00 :
               (m_wr && m_op != OP_LOAD && m_rd == x_rs2) ? 2'b01 :
               (w_wr && w_rd == x_rs2) ? 2'b10 : 2'b00;
    end

    always_comb begin
        MemRW  = m_valid && m_op == OP_STORE;
        Size   = m_inst[14:12];
        WBSel  = w_op == OP_LUI ? 2'b11 :
                 w_op == OP_LOAD ? 2'b00 :
                 (w_op == OP_JAL || w_op == OP_JALR) ? 2'b10 : 2'b01;
        RegWEn = w_wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_inst  <= NOP;
            m_inst  <= NOP;
            w_inst  <= NOP;
            x_valid <= 1'b0;
            m_valid <= 1'b0;
            w_valid <= 1'b0;
        end else begin
            x_inst  <= bubble ? NOP : inst_d;
            x_valid <= valid_d && !bubble;
            m_inst  <= x_inst;
            m_valid <= x_valid;
            w_inst  <= m_inst;
            w_valid <= m_valid;
        end
    end
endmodule

// File: tb/tb_controller_hazard.sv
// tb_controller_hazard: directed scenarios plus random instruction streams on a
// forwarding and a non-forwarding instance, checked against a behavioural model.
module tb_controller_hazard;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] LW     = 32'h0000A283;
    localparam logic [31:0] ADD_LU = 32'h00728333;
    localparam logic [31:0] ADD_A  = 32'h002082B3;
    localparam logic [31:0] SUB    = 32'h40328333;
    localparam logic [31:0] BEQ    = 32'h00208063;
    localparam logic [31:0] SW     = 32'h00322023;

    typedef enum {K_R, K_I, K_LD, K_ST, K_BR, K_LUI, K_AUIPC, K_JAL, K_JALR, K_X} kind_t;
    typedef struct {
        kind_t      k;
        logic       v, wr, r1, r2, b30;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
    } dec_t;
    typedef struct packed {
        logic       stall, flush, pcsel;
        logic [2:0] imm;
        logic       brun, asel, bsel;
        logic [3:0] alu;
        logic [1:0] fa, fb;
        logic       memrw;
        logic [2:0] size;
        logic [1:0] wb;
        logic       regwen;
    } out_t;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic [31:0] inst_d = NOP;
    logic        valid_d = 1'b0, br_eq = 1'b0, br_lt = 1'b0;
    int          total = 0, bad = 0;

    logic       stall1, flush1, pcsel1, brun1, asel1, bsel1, memrw1, regwen1;
    logic [2:0] imm1, size1;
    logic [3:0] alu1;
    logic [1:0] fa1, fb1, wb1;
    logic       stall0, flush0, pcsel0, brun0, asel0, bsel0, memrw0, regwen0;
    logic [2:0] imm0, size0;
    logic [3:0] alu0;
    logic [1:0] fa0, fb0, wb0;
    out_t       g1, g0;

    logic [31:0] mi [2][3];
    logic        mv [2][3];

    always #5 clk = ~clk;

    controller_hazard #(.DWIDTH(32), .FWD_EN(1), .NOP(NOP)) dut1 (
        .clk(clk), .rst_n(rst_n), .inst_d(inst_d), .valid_d(valid_d), .BrEq(br_eq), .BrLT(br_lt),
        .stall(stall1), .flush(flush1), .PCSel(pcsel1), .ImmSel(imm1), .BrUn(brun1), .ASel(asel1),
        .BSel(bsel1), .ALUSel(alu1), .FwdA(fa1), .FwdB(fb1), .MemRW(memrw1), .Size(size1),
        .WBSel(wb1), .RegWEn(regwen1));

    controller_hazard #(.DWIDTH(32), .FWD_EN(0), .NOP(NOP)) dut0 (
        .clk(clk), .rst_n(rst_n), .inst_d(inst_d), .valid_d(valid_d), .BrEq(br_eq), .BrLT(br_lt),
        .stall(stall0), .flush(flush0), .PCSel(pcsel0), .ImmSel(imm0), .BrUn(brun0), .ASel(asel0),
        .BSel(bsel0), .ALUSel(alu0), .FwdA(fa0), .FwdB(fb0), .MemRW(memrw0), .Size(size0),
        .WBSel(wb0), .RegWEn(regwen0));

    assign g1 = {stall1, flush1, pcsel1, imm1, brun1, asel1, bsel1, alu1, fa1, fb1, memrw1, size1, wb1, regwen1};
    assign g0 = {stall0, flush0, pcsel0, imm0, brun0, asel0, bsel0, alu0, fa0, fb0, memrw0, size0, wb0, regwen0};

    function automatic dec_t dec(input logic [31:0] i, input logic v);
        dec_t d;
        case (i[6:2])
            5'b01100: d.k = K_R;
            5'b00100: d.k = K_I;
            5'b00000: d.k = K_LD;
            5'b01000: d.k = K_ST;
            5'b11000: d.k = K_BR;
            5'b01101: d.k = K_LUI;
            5'b00101: d.k = K_AUIPC;
            5'b11011: d.k = K_JAL;
            5'b11001: d.k = K_JALR;
            default:  d.k = K_X;
        endcase
        d.v   = v;
        d.rd  = i[11:7];
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.f3  = i[14:12];
        d.b30 = i[30];
        d.wr  = v && d.k != K_ST && d.k != K_BR && d.rd != 5'd0;
        d.r1  = !(d.k inside {K_LUI, K_AUIPC, K_JAL});
        d.r2  = d.k inside {K_R, K_ST, K_BR};
        return d;
    endfunction

    function automatic logic hits(input dec_t c, input dec_t p);
        return p.wr && ((c.r1 && c.rs1 == p.rd) || (c.r2 && c.rs2 == p.rd));
    endfunction

    function automatic logic [1:0] src(input int fe, input logic rd_it, input logic [4:0] rs,
                                       input dec_t m, input dec_t w);
        if (fe == 0 || !rd_it) return 2'b00;
        if (m.wr && m.k != K_LD && m.rd == rs) return 2'b01;
        if (w.wr && w.rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic out_t model(input int fe, input logic [31:0] di, input logic dv,
                                   input logic be, input logic bl);
        dec_t x = dec(mi[fe][0], mv[fe][0]);
        dec_t m = dec(mi[fe][1], mv[fe][1]);
        dec_t w = dec(mi[fe][2], mv[fe][2]);
        dec_t d = dec(di, dv);
        out_t o;
        logic taken;
        case (x.f3)
            3'd0:       taken = be;
            3'd1:       taken = !be;
            3'd4, 3'd6: taken = bl;
            default:    taken = !bl;
        endcase
        o.pcsel  = x.v && ((x.k == K_BR && taken) || x.k == K_JAL || x.k == K_JALR);
        o.flush  = o.pcsel;
        o.stall  = !o.pcsel && dv && (fe == 1 ? (x.k == K_LD && hits(d, x)) : (hits(d, x) || hits(d, m)));
        o.imm    = x.k == K_ST ? 3'd1 : x.k == K_BR ? 3'd2 : (x.k == K_LUI || x.k == K_AUIPC) ? 3'd3 :
                   x.k == K_JAL ? 3'd4 : 3'd0;
        o.brun   = x.f3[2] & x.f3[1];
        o.asel   = x.k inside {K_BR, K_AUIPC, K_JAL};
        o.bsel   = x.k != K_R;
        o.alu    = x.k == K_R ? {x.b30, x.f3} : x.k == K_I ? {1'b0, x.f3} : 4'd0;
        o.fa     = src(fe, x.r1, x.rs1, m, w);
        o.fb     = src(fe, x.r2, x.rs2, m, w);
        o.memrw  = m.v && m.k == K_ST;
        o.size   = m.f3;
        o.wb     = w.k == K_LUI ? 2'b11 : w.k == K_LD ? 2'b00 : (w.k inside {K_JAL, K_JALR}) ? 2'b10 : 2'b01;
        o.regwen = w.wr;
        return o;
    endfunction

    function automatic logic bubble(input int fe);
        out_t o = model(fe, inst_d, valid_d, br_eq, br_lt);
        return o.stall || o.flush;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < 2; f++)
                for (int s = 0; s < 3; s++) begin
                    mi[f][s] <= NOP;
                    mv[f][s] <= 1'b0;
                end
        end else begin
            for (int f = 0; f < 2; f++) begin
                mi[f][2] <= mi[f][1];
                mv[f][2] <= mv[f][1];
                mi[f][1] <= mi[f][0];
                mv[f][1] <= mv[f][0];
                mi[f][0] <= bubble(f) ? NOP : inst_d;
                mv[f][0] <= valid_d && !bubble(f);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("model_fwd", {8'b0, g1}, {8'b0, model(1, inst_d, valid_d, br_eq, br_lt)});
        check("model_nofwd", {8'b0, g0}, {8'b0, model(0, inst_d, valid_d, br_eq, br_lt)});
    endtask

    task automatic cyc(input logic [31:0] i, input logic v, input logic be, input logic bl);
        @(posedge clk);
        #1;
        inst_d  = i;
        valid_d = v;
        br_eq   = be;
        br_lt   = bl;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(NOP, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r = $urandom;
        int k = $urandom_range(0, 8);
        int f = $urandom_range(0, 5);
        case (k)
            0: r[6:0] = 7'b0110011;
            1: r[6:0] = 7'b0010011;
            2: r[6:0] = 7'b0000011;
            3: r[6:0] = 7'b0100011;
            4: r[6:0] = 7'b0110111;
            5: r[6:0] = 7'b0010111;
            6: r[6:0] = 7'b1100011;
            7: r[6:0] = 7'b1101111;
            default: r[6:0] = 7'b1100111;
        endcase
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        if (k == 0) r[31:25] = {1'b0, 1'($urandom), 5'b0};
        if (k == 6) r[14:12] = 3'(f < 2 ? f : f + 2);
        return r;
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        inst_d  = LW;
        valid_d = 1'b1;
        @(negedge clk);
        check_all();
        check("rst_stall", 32'(stall1), 32'd0);
        check("rst_pcsel", 32'(pcsel1), 32'd0);
        check("rst_memrw", 32'(memrw1), 32'd0);
        check("rst_fwd", 32'({fa1, fb1}), 32'd0);
        check("rst_wbsel", 32'(wb1), 32'd1);
        check("rst_regwen", 32'(regwen1), 32'd0);
        check("rst_bsel", 32'(bsel1), 32'd1);
        @(negedge clk);
        check("rst_held", 32'({stall0, flush0, regwen0, memrw0}), 32'd0);
        valid_d = 1'b0;
        inst_d  = NOP;
        @(negedge clk);
        rst_n = 1'b1;

        cyc(LW, 1'b1, 1'b0, 1'b0);
        cyc(ADD_LU, 1'b1, 1'b0, 1'b0);
        check("lu_stall", 32'(stall1), 32'd1);
        cyc(ADD_LU, 1'b1, 1'b0, 1'b0);
        check("lu_one_cycle", 32'(stall1), 32'd0);
        cyc(NOP, 1'b0, 1'b0, 1'b0);
        check("lu_fwda", 32'(fa1), 32'd2);
        check("lu_fwdb", 32'(fb1), 32'd0);
        idle(3);

        cyc(ADD_A, 1'b1, 1'b0, 1'b0);
        cyc(SUB, 1'b1, 1'b0, 1'b0);
        check("aa_nostall", 32'(stall1), 32'd0);
        cyc(NOP, 1'b0, 1'b0, 1'b0);
        check("aa_fwda", 32'(fa1), 32'd1);
        check("aa_alusel", 32'(alu1), 32'h8);
        check("aa_nostall2", 32'(stall1), 32'd0);
        idle(3);

        cyc(ADD_A, 1'b1, 1'b0, 1'b0);
        cyc(SUB, 1'b1, 1'b0, 1'b0);
        check("nf_stall1", 32'(stall0), 32'd1);
        check("nf_fwd1", 32'({fa0, fb0}), 32'd0);
        cyc(SUB, 1'b1, 1'b0, 1'b0);
        check("nf_stall2", 32'(stall0), 32'd1);
        cyc(SUB, 1'b1, 1'b0, 1'b0);
        check("nf_stall_end", 32'(stall0), 32'd0);
        cyc(NOP, 1'b0, 1'b0, 1'b0);
        check("nf_fwd_x", 32'({fa0, fb0}), 32'd0);
        idle(3);

        cyc(ADD_A, 1'b1, 1'b0, 1'b0);
        cyc(BEQ, 1'b1, 1'b0, 1'b0);
        cyc(ADD_LU, 1'b1, 1'b1, 1'b0);
        check("br_pcsel", 32'(pcsel1), 32'd1);
        check("br_flush", 32'(flush1), 32'd1);
        check("br_pcsel_nf", 32'(pcsel0), 32'd1);
        check("br_stall_nf", 32'(stall0), 32'd0);
        cyc(NOP, 1'b0, 1'b1, 1'b0);
        check("br_bubble_bsel", 32'(bsel1), 32'd1);
        check("br_bubble_pcsel", 32'(pcsel1), 32'd0);
        cyc(BEQ, 1'b1, 1'b0, 1'b0);
        cyc(NOP, 1'b0, 1'b0, 1'b0);
        check("br_not_taken", 32'(pcsel1), 32'd0);
        idle(3);

        cyc(ADD_A, 1'b1, 1'b0, 1'b0);
        cyc(SW, 1'b1, 1'b0, 1'b0);
        cyc(NOP, 1'b0, 1'b0, 1'b0);
        cyc(NOP, 1'b0, 1'b0, 1'b0);
        check("mid_memrw_pre", 32'(memrw1), 32'd1);
        check("mid_regwen_pre", 32'(regwen1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_memrw", 32'(memrw1), 32'd0);
        check("mid_regwen", 32'(regwen1), 32'd0);
        check("mid_memrw_nf", 32'(memrw0), 32'd0);
        check("mid_regwen_nf", 32'(regwen0), 32'd0);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        idle(3);

        for (int n = 0; n < 400; n++)
            cyc(rand_inst(), $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
